turbo_encoding: RTL and testbench

TURBO_ENCODING -- requirements
Module: turbo_encoding

---
 rtl/turbo_encoding.sv | 173 +++++++++++++++++
 tb/tb_turbo_encoding.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_encoding.sv
// Rate-1/3 turbo encoder: buffers K bits, then streams sys/parity1/parity2
// symbols from two RSC (7,5) encoders, the second fed through an interleaver.
module turbo_encoding #(
  parameter int K    = 8,
  parameter int AMP  = 64,
  parameter int IL_P = 3,
  parameter int IL_S = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_sym,
  output logic        [1:0] out_type,
  output logic              out_last
);

  localparam int LW = $clog2(K);
  localparam logic [LW-1:0] ILP = LW'(IL_P);
  localparam logic [LW-1:0] ILS = LW'(IL_S);
  localparam logic [LW-1:0] KM1 = LW'(K - 1);
  localparam logic [7:0] PAMP = 8'(AMP);
  localparam logic [7:0] NAMP = 8'(-AMP);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [LW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [1:0]        ph_q, ph_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic              t1_q, t1_d, t2_q, t2_d;
  logic              ov_q, ov_d;
  logic signed [7:0] sym_q, sym_d;
  logic [1:0]        typ_q, typ_d;
  logic              last_q, last_d;
  logic [K-1:0]      buf_q;

  logic [LW-1:0] pidx, idx_nx;
  logic          ubit, vbit, fire;

  function automatic logic [7:0] map(input logic b);
    return b ? PAMP : NAMP;
  endfunction

  assign pidx   = ILP * idx_q + ILS;
  assign idx_nx = idx_q + LW'(1);
  assign ubit   = buf_q[idx_q];
  assign vbit   = buf_q[pidx];
  assign fire   = ov_q & out_ready;

  assign in_ready  = rst & (state_q == S_LOAD);
  assign out_valid = ov_q;
  assign out_sym   = sym_q;
  assign out_type  = typ_q;
  assign out_last  = last_q;

  // Output regs hold the next symbol; parity is formed from the
  // encoder state just before that encoder advances.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    idx_d    = idx_q;
    ph_d     = ph_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    ov_d     = ov_q;
    sym_d    = sym_q;
    typ_d    = typ_q;
    last_d   = last_q;
    unique case (1'b1)
      (state_q == S_LOAD): begin
        if (in_valid) begin
          wr_cnt_d = wr_cnt_q + LW'(1);
          if (wr_cnt_q == KM1) begin
            state_d = S_EMIT;
            idx_d   = '0;
            ph_d    = 2'd0;
            s1_d    = 1'b0;
            s2_d    = 1'b0;
            t1_d    = 1'b0;
            t2_d    = 1'b0;
            ov_d    = 1'b1;
            sym_d   = map(buf_q[0]);
            typ_d   = 2'd0;
            last_d  = 1'b0;
          end
        end
      end
      fire: begin
        case (ph_q)
          2'd0: begin
            s1_d  = ubit ^ s1_q ^ s2_q;
            s2_d  = s1_q;
            sym_d = map(ubit ^ s1_q);
            typ_d = 2'd1;
            ph_d  = 2'd1;
          end
          2'd1: begin
            sym_d  = map(vbit ^ t1_q);
            typ_d  = 2'd2;
            ph_d   = 2'd2;
            last_d = (idx_q == KM1);
          end
          default: begin
            t1_d = vbit ^ t1_q ^ t2_q;
            t2_d = t1_q;
            ph_d = 2'd0;
            if (last_q) begin
              state_d  = S_LOAD;
              wr_cnt_d = '0;
              idx_d    = '0;
              ov_d     = 1'b0;
              last_d   = 1'b0;
              s1_d     = 1'b0;
              s2_d     = 1'b0;
              t1_d     = 1'b0;
              t2_d     = 1'b0;
            end else begin
              idx_d = idx_nx;
              sym_d = map(buf_q[idx_nx]);
              typ_d = 2'd0;
            end
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      wr_cnt_q <= '0;
      idx_q    <= '0;
      ph_q     <= 2'd0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      t1_q     <= 1'b0;
      t2_q     <= 1'b0;
      ov_q     <= 1'b0;
      sym_q    <= '0;
      typ_q    <= 2'd0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      idx_q    <= idx_d;
      ph_q     <= ph_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      ov_q     <= ov_d;
      sym_q    <= sym_d;
      typ_q    <= typ_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid) begin
      buf_q[wr_cnt_q] <= in_bit;
    end
  end

endmodule

// File: tb/tb_turbo_encoding.sv
// Scoreboard bench for turbo_encoding (K=8, AMP=64, IL_P=3, IL_S=5).
module tb_turbo_encoding;

  localparam int K    = 8;
  localparam int AMP  = 64;
  localparam int IL_P = 3;
  localparam int IL_S = 5;

  typedef struct packed {
    logic [7:0] sym;
    logic [1:0] typ;
    logic       last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_sym;
  logic        [1:0] out_type;
  logic              out_last;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  turbo_encoding #(
    .K(K), .AMP(AMP), .IL_P(IL_P), .IL_S(IL_S)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_type(out_type), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] amp(input logic b);
    return b ? 8'(AMP) : 8'(-AMP);
  endfunction

  // Golden model: literal RSC recursion plus modular interleaver.
  task automatic push_model(input logic [K-1:0] u);
    logic s1, s2, t1, t2, a, p1, p2, v;
    int j;
    s1 = 0; s2 = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < K; i++) begin
      a  = u[i] ^ s1 ^ s2;
      p1 = a ^ s2;
      s2 = s1; s1 = a;
      j  = (IL_P * i + IL_S) % K;
      v  = u[j];
      a  = v ^ t1 ^ t2;
      p2 = a ^ t2;
      t2 = t1; t1 = a;
      q.push_back('{amp(u[i]), 2'd0, 1'b0});
      q.push_back('{amp(p1), 2'd1, 1'b0});
      q.push_back('{amp(p2), 2'd2, i == K - 1});
    end
  endtask

  task automatic load_block(input logic [K-1:0] u);
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL load_ready bit%0d: in_ready=%b out_valid=%b, want 1/0",
                 i, in_ready, out_valid);
      end
      in_valid = 1'b1;
      in_bit   = u[i];
    end
  endtask

  // mode 0: in_valid low, 1: held high, 2: random pulses
  task automatic drain(input int pct, input int mode, input int max_syms,
                       input int budget);
    int   n = 0;
    bit   held = 0;
    bit   done = 0;
    exp_t h, e;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (held) begin
        tests++;
        if (out_valid !== 1'b1 || {out_sym, out_type, out_last} !== h) begin
          fails++;
          $display("FAIL stall_hold: got v=%b %0d/%0d/%b want %0d/%0d/%b",
                   out_valid, out_sym, out_type, out_last,
                   $signed(h.sym), h.typ, h.last);
        end
      end
      case (mode)
        0: in_valid = 1'b0;
        1: in_valid = 1'b1;
        default: in_valid = 1'($urandom_range(1));
      endcase
      in_bit = 1'($urandom_range(1));
      if (out_valid) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL emit_in_ready: got %b want 0", in_ready);
        end
      end
      out_ready = ($urandom_range(99) < pct);
      held = 0;
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_sym: got %0d/%0d with empty scoreboard",
                   out_sym, out_type);
        end else begin
          e = q.pop_front();
          if ({out_sym, out_type, out_last} !== e) begin
            fails++;
            $display("FAIL sym%0d: got %0d/%0d/%b want %0d/%0d/%b",
                     n, out_sym, out_type, out_last,
                     $signed(e.sym), e.typ, e.last);
          end
          if (e.last) done = 1;
        end
        n++;
        if (n == max_syms) done = 1;
      end else if (out_valid) begin
        held = 1;
        h = {out_sym, out_type, out_last};
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d symbols, %0d still expected",
               n, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 0 || out_sym !== 0 || out_type !== 0 ||
        out_last !== 0 || in_ready !== 0) begin
      fails++;
      $display("FAIL reset_state: v=%b s=%0d t=%0d l=%b r=%b want all 0",
               out_valid, out_sym, out_type, out_last, in_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 3 * K; i++)
      q.push_back('{8'(-AMP), 2'(i % 3), i == 3 * K - 1});
    load_block('0);
    drain(100, 0, 3 * K, 100);
  endtask

  task automatic test_impulse();
    logic [K-1:0] sys, p1, p2;
    sys = 8'b0000_0001;
    p1  = 8'b1011_0111;
    p2  = 8'b0110_1110;
    for (int i = 0; i < K; i++) begin
      q.push_back('{amp(sys[i]), 2'd0, 1'b0});
      q.push_back('{amp(p1[i]), 2'd1, 1'b0});
      q.push_back('{amp(p2[i]), 2'd2, i == K - 1});
    end
    load_block(8'b0000_0001);
    drain(100, 0, 3 * K, 100);
  endtask

  task automatic test_random_stall();
    logic [K-1:0] u;
    for (int b = 0; b < 4; b++) begin
      u = K'($urandom);
      push_model(u);
      load_block(u);
      drain(50, 0, 3 * K, 400);
    end
  endtask

  task automatic test_emit_ignore();
    logic [K-1:0] u;
    u = 8'b1100_1010;
    push_model(u);
    load_block(u);
    drain(70, 2, 3 * K, 300);
    u = 8'b0101_1001;
    push_model(u);
    load_block(u);
    drain(100, 0, 3 * K, 100);
  endtask

  task automatic test_mid_reset();
    logic [K-1:0] u;
    u = 8'b1001_0110;
    push_model(u);
    load_block(u);
    drain(100, 0, 10, 100);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 0 || out_sym !== 0 || out_type !== 0 ||
        out_last !== 0 || in_ready !== 0) begin
      fails++;
      $display("FAIL mid_reset: v=%b s=%0d t=%0d l=%b r=%b want all 0",
               out_valid, out_sym, out_type, out_last, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL post_reset_idle: v=%b r=%b want 0/1",
                 out_valid, in_ready);
      end
    end
    push_model('1);
    load_block('1);
    drain(100, 0, 3 * K, 100);
  endtask

  task automatic test_back_to_back();
    logic [K-1:0] u1, u2;
    u1 = 8'b0011_1010;
    u2 = 8'b1110_0101;
    push_model(u1);
    load_block(u1);
    drain(100, 1, 3 * K, 100);
    push_model(u2);
    load_block(u2);
    drain(100, 0, 3 * K, 100);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_impulse();
    test_random_stall();
    test_emit_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
